// File: rtl/bias_grad_accumulator.sv
// Column-wise bias-gradient accumulator: sums a row-major stream of Q8.8 gradients
// over a batch with saturation, then drains the per-column sums through valid/ready.
module bias_grad_accumulator #(
  parameter int unsigned NUM_COLS = 4,
  parameter int unsigned BATCH_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BATCH_W-1:0] batch_size_in,
  input  logic signed [15:0] grad_in,
  input  logic               grad_valid_in,
  output logic               grad_ready_out,
  output logic signed [15:0] bias_grad_out,
  output logic               bias_grad_valid_out,
  input  logic               bias_grad_ready_in,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int unsigned ColW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(NUM_COLS - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e state_q, state_d;

  logic [BATCH_W-1:0] batch_q, batch_d;
  logic [BATCH_W-1:0] row_q, row_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [ColW-1:0]    idx_q, idx_d;
  logic signed [15:0] acc_q [NUM_COLS];
  logic signed [15:0] acc_d [NUM_COLS];
  logic signed [15:0] out_q, out_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic               start_ok;
  logic               grad_fire;
  logic               last_in;
  logic               out_fire;
  logic               last_out;
  logic signed [16:0] sum;
  logic signed [15:0] sat;
  logic               clamp;
  logic [ColW-1:0]    idx_nxt;

  assign start_ok  = (state_q == StIdle) && start && (batch_size_in != '0);
  assign grad_fire = (state_q == StAccum) && grad_valid_in;
  assign last_in   = grad_fire && (col_q == LastCol) && (row_q == batch_q - BATCH_W'(1));
  assign out_fire  = valid_q && bias_grad_ready_in;
  assign last_out  = out_fire && (idx_q == LastCol);
  assign idx_nxt   = idx_q + ColW'(1);

  // 17-bit sum so the carry into the sign bit exposes overflow before clamping.
  always_comb begin
    sum   = {acc_q[col_q][15], acc_q[col_q]} + {grad_in[15], grad_in};
    sat   = sum[15:0];
    clamp = 1'b0;
    if (sum[16] != sum[15]) begin
      clamp = 1'b1;
      sat   = sum[16] ? 16'sh8000 : 16'sh7fff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StAccum;
      StAccum: if (last_in) state_d = StDrain;
      StDrain: if (last_out) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grad_ready_out = (state_q == StAccum);
    busy           = (state_q != StIdle);
  end

  always_comb begin
    batch_d = batch_q;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;

    if (start_ok) begin
      batch_d = batch_size_in;
      row_d   = '0;
      col_d   = '0;
      ovf_d   = 1'b0;
      for (int i = 0; i < int'(NUM_COLS); i++) begin
        acc_d[i] = '0;
      end
    end

    if (grad_fire) begin
      acc_d[col_q] = sat;
      if (clamp) ovf_d = 1'b1;
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = row_q + BATCH_W'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end

    // Present the first sum straight away, including the value just accumulated.
    if (last_in) begin
      idx_d   = '0;
      out_d   = acc_d[0];
      valid_d = 1'b1;
    end

    if (out_fire) begin
      if (idx_q == LastCol) begin
        valid_d = 1'b0;
        done_d  = 1'b1;
      end else begin
        idx_d = idx_nxt;
        out_d = acc_q[idx_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      batch_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_COLS); i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      batch_q <= batch_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
    end
  end

  assign bias_grad_out       = out_q;
  assign bias_grad_valid_out = valid_q;
  assign done                = done_q;
  assign overflow            = ovf_q;

endmodule

// File: tb/tb_bias_grad_accumulator.sv
// Self-checking bench for bias_grad_accumulator: directed scenarios plus random batches
// checked against a saturating column-sum model.
module tb_bias_grad_accumulator;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  batch_size_in;
  logic [15:0] grad_in;
  logic        grad_valid_in;
  logic        grad_ready_out;
  logic [15:0] bias_grad_out;
  logic        bias_grad_valid_out;
  logic        bias_grad_ready_in;
  logic        busy;
  logic        done;
  logic        overflow;

  bias_grad_accumulator #(
    .NUM_COLS(NC),
    .BATCH_W (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .batch_size_in      (batch_size_in),
    .grad_in            (grad_in),
    .grad_valid_in      (grad_valid_in),
    .grad_ready_out     (grad_ready_out),
    .bias_grad_out      (bias_grad_out),
    .bias_grad_valid_out(bias_grad_valid_out),
    .bias_grad_ready_in (bias_grad_ready_in),
    .busy               (busy),
    .done               (done),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] stim[$];
  int          exp_sum[NC];
  bit          exp_ovf;
  logic [15:0] got[NC];
  int          n_got;
  int          drain_cycles;
  bit          timeout;
  bit          stall_ok;
  logic        done_hit;
  logic        done_after;
  logic        valid_after;
  logic        busy_after;
  int          ready_miss;
  logic        last_valid;
  logic [15:0] last_out;

  // Reference: each column is a running sum clamped to 16-bit signed after every row.
  function automatic void model(input int nb);
    exp_ovf = 1'b0;
    for (int c = 0; c < NC; c++) begin
      int s;
      s = 0;
      for (int r = 0; r < nb; r++) begin
        s = s + int'($signed(stim[r * NC + c]));
        if (s > 32767) begin
          s = 32767;
          exp_ovf = 1'b1;
        end else if (s < -32768) begin
          s = -32768;
          exp_ovf = 1'b1;
        end
      end
      exp_sum[c] = s;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input int n);
    start         = 1'b1;
    batch_size_in = 8'(n);
    step();
    start      = 1'b0;
    ready_miss = 0;
  endtask

  // mode 0: no bubbles, 1: random bubbles, 2: strictly alternating valid.
  task automatic feed(input int from, input int to, input int mode);
    for (int i = from; i < to; i++) begin
      if (mode == 1) begin
        for (int b = 0; b < 3 && $urandom_range(0, 1) == 1; b++) begin
          grad_valid_in = 1'b0;
          grad_in       = 16'($urandom);
          step();
        end
      end else if (mode == 2 && i != from) begin
        grad_valid_in = 1'b0;
        grad_in       = 16'($urandom);
        step();
      end
      grad_valid_in = 1'b1;
      grad_in       = stim[i];
      if (grad_ready_out !== 1'b1) ready_miss++;
      step();
    end
    grad_valid_in = 1'b0;
    grad_in       = 16'($urandom);
    last_valid    = bias_grad_valid_out;
    last_out      = bias_grad_out;
  endtask

  task automatic drain(input int stall_first, input bit rand_ready);
    int          stall_left;
    bit          prev_stall;
    logic [15:0] prev_out;
    int          cyc;
    stall_left = stall_first;
    prev_stall = 1'b0;
    prev_out   = '0;
    cyc        = 0;
    n_got      = 0;
    timeout    = 1'b0;
    stall_ok   = 1'b1;
    while (n_got < NC) begin
      if (cyc >= 200) begin
        timeout = 1'b1;
        break;
      end
      if (prev_stall && (bias_grad_valid_out !== 1'b1 || bias_grad_out !== prev_out))
        stall_ok = 1'b0;
      if (n_got == 0 && stall_left > 0) begin
        bias_grad_ready_in = 1'b0;
        stall_left--;
      end else begin
        bias_grad_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (bias_grad_valid_out === 1'b1 && bias_grad_ready_in) begin
        got[n_got] = bias_grad_out;
        n_got++;
      end
      prev_stall = (bias_grad_valid_out === 1'b1) && !bias_grad_ready_in;
      prev_out   = bias_grad_out;
      step();
      cyc++;
    end
    drain_cycles       = cyc;
    bias_grad_ready_in = 1'b0;
    done_hit           = done;
    valid_after        = bias_grad_valid_out;
    busy_after         = busy;
    step();
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    batch_size_in = '0;
    grad_in = '0;
    grad_valid_in = 1'b0;
    bias_grad_ready_in = 1'b0;
    step();
    step();
    checks++;
    if ({busy, grad_ready_out, bias_grad_valid_out, done, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {busy, grad_ready_out, bias_grad_valid_out, done, overflow});
    end
    checks++;
    if (bias_grad_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_out: got %h expected 0000", bias_grad_out);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    stim.delete();
    for (int i = 0; i < 2 * NC; i++) stim.push_back(16'h0100);
    model(2);
    start_batch(2);
    feed(0, 2 * NC, 0);
    checks++;
    if (last_valid !== 1'b1 || last_out !== 16'(exp_sum[0])) begin
      errors++;
      $display("FAIL basic_latency: got valid=%b out=%h expected valid=1 out=%h",
               last_valid, last_out, 16'(exp_sum[0]));
    end
    drain(0, 1'b0);
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (got[k] !== 16'(exp_sum[k])) begin
        errors++;
        $display("FAIL basic_sum[%0d]: got %h expected %h", k, got[k], 16'(exp_sum[k]));
      end
    end
    checks++;
    if (timeout || drain_cycles != NC) begin
      errors++;
      $display("FAIL basic_rate: got %0d cycles timeout=%0b expected %0d cycles",
               drain_cycles, timeout, NC);
    end
    checks++;
    if (done_hit !== 1'b1 || done_after !== 1'b0 || valid_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%b,%b valid=%b expected 1,0 valid=0",
               done_hit, done_after, valid_after);
    end
    checks++;
    if (overflow !== 1'b0 || ready_miss != 0) begin
      errors++;
      $display("FAIL basic_ovf_ready: got ovf=%b miss=%0d expected ovf=0 miss=0",
               overflow, ready_miss);
    end
  endtask

  task automatic test_mixed();
    logic [15:0] vals [8];
    vals = '{16'h0180, 16'hFF00, 16'h0040, 16'h0000,
             16'hFF80, 16'hFF00, 16'h0040, 16'h0010};
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(vals[i]);
    model(2);
    start_batch(2);
    feed(0, 8, 0);
    drain(0, 1'b0);
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (timeout || got[k] !== 16'(exp_sum[k])) begin
        errors++;
        $display("FAIL mixed_sum[%0d]: got %h expected %h", k, got[k], 16'(exp_sum[k]));
      end
    end
  endtask

  task automatic test_saturation();
    stim.delete();
    for (int r = 0; r < 3; r++) begin
      stim.push_back(16'h7000);
      stim.push_back(16'h9000);
      stim.push_back(16'h0001);
      stim.push_back(16'hFFFF);
    end
    model(3);
    start_batch(3);
    feed(0, 3 * NC, 0);
    drain(0, 1'b0);
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (timeout || got[k] !== 16'(exp_sum[k])) begin
        errors++;
        $display("FAIL sat_sum[%0d]: got %h expected %h", k, got[k], 16'(exp_sum[k]));
      end
    end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL sat_overflow: got %b expected %b", overflow, exp_ovf);
    end
    stim.delete();
    for (int i = 0; i < NC; i++) stim.push_back(16'h0000);
    model(1);
    start_batch(1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: got %b expected 0", overflow);
    end
    feed(0, NC, 0);
    drain(0, 1'b0);
  endtask

  task automatic test_backpressure();
    stim.delete();
    for (int i = 0; i < 2 * NC; i++) stim.push_back(16'(16'h0011 * (i + 1)));
    model(2);
    start_batch(2);
    feed(0, 2 * NC, 2);
    drain(3, 1'b0);
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (timeout || got[k] !== 16'(exp_sum[k])) begin
        errors++;
        $display("FAIL bp_sum[%0d]: got %h expected %h", k, got[k], 16'(exp_sum[k]));
      end
    end
    checks++;
    if (!stall_ok || drain_cycles != NC + 3) begin
      errors++;
      $display("FAIL bp_stall: got stable=%0b cycles=%0d expected stable=1 cycles=%0d",
               stall_ok, drain_cycles, NC + 3);
    end
  endtask

  task automatic test_ignored_starts();
    start = 1'b1;
    batch_size_in = 8'd0;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || grad_ready_out !== 1'b0) begin
      errors++;
      $display("FAIL ign_zero: got busy=%b ready=%b expected 0 0", busy, grad_ready_out);
    end
    stim.delete();
    for (int i = 0; i < 2 * NC; i++) stim.push_back(16'($urandom_range(0, 16'h0400)));
    model(2);
    start_batch(2);
    feed(0, 3, 0);
    start = 1'b1;
    batch_size_in = 8'd1;
    step();
    start = 1'b0;
    feed(3, 2 * NC, 0);
    start = 1'b1;
    batch_size_in = 8'd3;
    bias_grad_ready_in = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (bias_grad_valid_out !== 1'b1 || bias_grad_out !== 16'(exp_sum[0])) begin
      errors++;
      $display("FAIL ign_drain_start: got valid=%b out=%h expected valid=1 out=%h",
               bias_grad_valid_out, bias_grad_out, 16'(exp_sum[0]));
    end
    drain(0, 1'b0);
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (timeout || got[k] !== 16'(exp_sum[k])) begin
        errors++;
        $display("FAIL ign_sum[%0d]: got %h expected %h", k, got[k], 16'(exp_sum[k]));
      end
    end
    checks++;
    if (busy_after !== 1'b0 || done_hit !== 1'b1) begin
      errors++;
      $display("FAIL ign_end: got busy=%b done=%b expected busy=0 done=1",
               busy_after, done_hit);
    end
  endtask

  task automatic test_reset_mid();
    stim.delete();
    for (int i = 0; i < 2 * NC; i++) stim.push_back(16'h0300);
    start_batch(2);
    feed(0, 5, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, grad_ready_out, bias_grad_valid_out, done, overflow} !== 5'b0 ||
        bias_grad_out !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_state: got flags=%b out=%h expected 00000 0000",
               {busy, grad_ready_out, bias_grad_valid_out, done, overflow}, bias_grad_out);
    end
    stim.delete();
    for (int i = 0; i < NC; i++) stim.push_back(16'(16'h0010 * (i + 1)));
    model(1);
    start_batch(1);
    feed(0, NC, 0);
    drain(0, 1'b0);
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (timeout || got[k] !== 16'(exp_sum[k])) begin
        errors++;
        $display("FAIL rstmid_sum[%0d]: got %h expected %h", k, got[k], 16'(exp_sum[k]));
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int nb;
      nb = $urandom_range(1, 5);
      stim.delete();
      for (int i = 0; i < nb * NC; i++) begin
        if ($urandom_range(0, 3) == 0) stim.push_back(16'($urandom));
        else stim.push_back(16'($signed($urandom_range(0, 16'h1000)) - 32'sh0800));
      end
      model(nb);
      start_batch(nb);
      feed(0, nb * NC, 1);
      drain(0, 1'b1);
      for (int k = 0; k < NC; k++) begin
        checks++;
        if (timeout || got[k] !== 16'(exp_sum[k])) begin
          errors++;
          $display("FAIL rand%0d_sum[%0d]: got %h expected %h",
                   t, k, got[k], 16'(exp_sum[k]));
        end
      end
      checks++;
      if (overflow !== exp_ovf || done_hit !== 1'b1 || ready_miss != 0) begin
        errors++;
        $display("FAIL rand%0d_flags: got ovf=%b done=%b miss=%0d expected ovf=%b done=1 miss=0",
                 t, overflow, done_hit, ready_miss, exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_saturation();
    test_backpressure();
    test_ignored_starts();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
